blake2s_comp: RTL and testbench

BLAKE2S_COMP -- requirements
Module: blake2s_comp

---
 rtl/blake2s_pkg.sv | 22 ++
 rtl/blake2s_g.sv | 27 ++
 rtl/blake2s_comp.sv | 115 +++++++++++
 tb/tb_blake2s_comp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/blake2s_pkg.sv
// blake2s_pkg: constants, message schedule and FSM states shared by the BLAKE2s compression core
package blake2s_pkg;
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  // each row packs 16 message-word indices, element k at bits [63-4k -: 4]
  localparam logic [0:9][63:0] SIGMA = {
    64'h0123456789abcdef, 64'hea489fd61c02b753, 64'hb8c052fdae367194,
    64'h7931dcbe265a40f8, 64'h905724afe1bc683d, 64'h2c6a0b834d75fe19,
    64'hc51fed4a0763928b, 64'hdb7ec13950f4862a, 64'h6fe9b308c2d714a5,
    64'ha2847615fb9e3cd0
  };
  localparam int R1 = 16;
  localparam int R2 = 12;
  localparam int R3 = 8;
  localparam int R4 = 7;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
endpackage

// File: rtl/blake2s_g.sv
// blake2s_g: combinational BLAKE2s G mixing function on four state words and two message words
module blake2s_g
  import blake2s_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);
  logic [31:0] a1, b1, c1, d1;
  always_comb begin
    a1 = a + b + x;
    d1 = ror(d ^ a1, R1);
    c1 = c + d1;
    b1 = ror(b ^ c1, R2);
    a_new = a1 + b1 + y;
    d_new = ror(d1 ^ a_new, R3);
    c_new = c1 + d_new;
    b_new = ror(b1 ^ c_new, R4);
  end
endmodule

// File: rtl/blake2s_comp.sv
// blake2s_comp: iterative BLAKE2s compression, one G per cycle, with a one-entry pending block slot
module blake2s_comp
  import blake2s_pkg::*;
#(
  parameter int W = 32,
  parameter int ROUNDS = 10,
  parameter int OUTLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            msg_strobe,
  input  logic [16*W-1:0] m_in,
  input  logic [2*W-1:0]  t_in,
  input  logic            f_in,
  output logic [8*W-1:0]  h_out,
  output logic            h_rdy,
  output logic            busy,
  output logic            overrun
);
  localparam int RW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
  localparam logic [W-1:0] H0 = IV[0] ^ 32'h01010000 ^ W'(OUTLEN);
  state_t state;
  logic cap, pend_v, pend_f, f_cur, src_f;
  logic [16*W-1:0] pend_m, m_blk, src_m;
  logic [2*W-1:0] pend_t, src_t;
  logic [W-1:0] h [8];
  logic [W-1:0] v [16];
  logic [W-1:0] v_init [16];
  logic [2:0] g;
  logic [RW-1:0] r;
  logic [3:0] ia, ib, ic, id, sx, sy, rm;
  logic [63:0] row;
  logic [W-1:0] a_new, b_new, c_new, d_new;
  assign src_m = pend_v ? pend_m : m_in;
  assign src_t = pend_v ? pend_t : t_in;
  assign src_f = pend_v ? pend_f : f_in;
  assign busy = state != IDLE || pend_v;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      v_init[i] = h[i];
      v_init[i+8] = IV[i];
      h_out[W*i +: W] = h[i];
    end
    v_init[12] = IV[4] ^ src_t[2*W-1:W];
    v_init[13] = IV[5] ^ src_t[W-1:0];
    v_init[14] = IV[6] ^ {W{src_f}};
  end
  // g[1:0] picks the column; g[2] shifts rows b/c/d by 1/2/3 for the diagonals
  assign ia = {2'b00, g[1:0]};
  assign ib = {2'b01, g[1:0] + {1'b0, g[2]}};
  assign ic = {2'b10, g[1:0] + {g[2], 1'b0}};
  assign id = {2'b11, g[1:0] + {g[2], g[2]}};
  assign rm = 4'(r % 10);
  assign row = SIGMA[rm];
  assign sx = row[63 - 8*g -: 4];
  assign sy = row[59 - 8*g -: 4];
  blake2s_g u_g (
    .a(v[ia]), .b(v[ib]), .c(v[ic]), .d(v[id]),
    .x(m_blk[W*sx +: W]), .y(m_blk[W*sy +: W]),
    .a_new(a_new), .b_new(b_new), .c_new(c_new), .d_new(d_new)
  );
  always_ff @(posedge clk) begin
    cap <= msg_strobe && !start && !rst;
    if (rst || start) begin
      for (int i = 0; i < 8; i++) h[i] <= i == 0 ? H0 : IV[i];
      state <= IDLE;
      pend_v <= 1'b0;
      overrun <= 1'b0;
      h_rdy <= 1'b0;
      g <= '0;
      r <= '0;
    end else begin
      h_rdy <= 1'b0;
      if (state == IDLE && pend_v) pend_v <= 1'b0;
      // a capture refills the slot even in the cycle the slot is being consumed
      if (cap && (state != IDLE || pend_v)) begin
        if (state != IDLE && pend_v) overrun <= 1'b1;
        else begin
          pend_v <= 1'b1;
          pend_m <= m_in;
          pend_t <= t_in;
          pend_f <= f_in;
        end
      end
      case (state)
        IDLE: if (cap || pend_v) begin
          for (int i = 0; i < 16; i++) v[i] <= v_init[i];
          m_blk <= src_m;
          f_cur <= src_f;
          g <= '0;
          r <= '0;
          state <= ROUND;
        end
        ROUND: begin
          v[ia] <= a_new;
          v[ib] <= b_new;
          v[ic] <= c_new;
          v[id] <= d_new;
          g <= g + 3'd1;
          if (g == 3'd7) begin
            r <= r + 1'b1;
            if (r == RW'(ROUNDS - 1)) state <= FINAL;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] ^ v[i] ^ v[i+8];
          h_rdy <= f_cur;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blake2s_comp.sv
// tb_blake2s_comp: directed checks of blake2s_comp against known digests and a behavioural model
module tb_blake2s_comp;
  logic clk = 1'b0;
  logic rst, start, msg_strobe, f_in;
  logic [511:0] m_in;
  logic [63:0] t_in;
  logic [255:0] h_out;
  logic h_rdy, busy, overrun;
  int checks = 0;
  int errors = 0;
  int rdy_cnt;
  logic [255:0] h_init, exp1, exp2;
  logic [511:0] abc_m, zero_m, blk_a, blk_b, blk_c;

  localparam logic [31:0] IVT [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam int SG [10][16] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
    '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
    '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
    '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
    '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
    '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
    '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
    '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}};
  localparam int GA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int GB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int GC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int GD [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

  blake2s_comp dut (
    .clk(clk), .rst(rst), .start(start), .msg_strobe(msg_strobe),
    .m_in(m_in), .t_in(t_in), .f_in(f_in),
    .h_out(h_out), .h_rdy(h_rdy), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model(input logic [255:0] hv, input logic [511:0] mb,
                                         input logic [31:0] t0, input logic [31:0] t1, input logic f);
    logic [31:0] v [16];
    logic [31:0] m [16];
    logic [255:0] res;
    int a, b, c, d;
    for (int i = 0; i < 16; i++) m[i] = mb[32*i +: 32];
    for (int i = 0; i < 8; i++) begin
      v[i] = hv[32*i +: 32];
      v[i+8] = IVT[i];
    end
    v[12] ^= t0;
    v[13] ^= t1;
    if (f) v[14] = ~v[14];
    for (int rd = 0; rd < 10; rd++)
      for (int s = 0; s < 8; s++) begin
        a = GA[s]; b = GB[s]; c = GC[s]; d = GD[s];
        v[a] = v[a] + v[b] + m[SG[rd][2*s]];
        v[d] = ror32(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = ror32(v[b] ^ v[c], 12);
        v[a] = v[a] + v[b] + m[SG[rd][2*s+1]];
        v[d] = ror32(v[d] ^ v[a], 8);
        v[c] = v[c] + v[d];
        v[b] = ror32(v[b] ^ v[c], 7);
      end
    for (int i = 0; i < 8; i++) res[32*i +: 32] = hv[32*i +: 32] ^ v[i] ^ v[i+8];
    return res;
  endfunction

  // digest hex strings list byte 0 first; h_out holds byte k at bits [8k +: 8]
  function automatic logic [255:0] le(input logic [255:0] s);
    logic [255:0] o;
    for (int k = 0; k < 32; k++) o[8*k +: 8] = s[255 - 8*k -: 8];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (h_rdy) rdy_cnt++;
    end
  endtask

  task automatic send(input logic [511:0] m, input logic [63:0] t, input logic f);
    msg_strobe = 1'b1;
    tick();
    msg_strobe = 1'b0;
    m_in = m;
    t_in = t;
    f_in = f;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; msg_strobe = 1'b0; f_in = 1'b0; m_in = '0; t_in = '0;
    for (int i = 0; i < 8; i++) h_init[32*i +: 32] = IVT[i];
    h_init[31:0] ^= 32'h01010020;
    abc_m = 512'h00636261;
    zero_m = '0;
    for (int i = 0; i < 64; i++) blk_a[8*i +: 8] = 8'(i);
    blk_b = 512'h40;
    blk_c = '1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_h", h_out, h_init);
    chk("reset_rdy", h_rdy, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);

    pulse_start();
    send(abc_m, {32'd3, 32'd0}, 1'b1);
    chk("abc_busy", busy, 1);
    wait_n(80);
    chk("abc_rdy_n82", h_rdy, 0);
    tick();
    chk("abc_rdy_n83", h_rdy, 1);
    chk("abc_digest", h_out, le(256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982));
    chk("abc_model", h_out, model(h_init, abc_m, 32'd3, 32'd0, 1'b1));
    exp1 = h_out;
    tick();
    chk("abc_rdy_n84", h_rdy, 0);
    chk("abc_h_stable", h_out, exp1);
    chk("abc_idle", busy, 0);

    pulse_start();
    chk("start_h", h_out, h_init);
    send(zero_m, 64'd0, 1'b1);
    for (int k = 0; k < 200 && !h_rdy; k++) tick();
    chk("zero_rdy", h_rdy, 1);
    chk("zero_digest", h_out, le(256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9));

    pulse_start();
    rdy_cnt = 0;
    send(blk_a, {32'd64, 32'd0}, 1'b0);
    wait_n(18);
    send(blk_b, {32'd128, 32'd0}, 1'b0);
    chk("ovr_pend_busy", busy, 1);
    chk("ovr_not_yet", overrun, 0);
    wait_n(18);
    send(blk_c, {32'd192, 32'd0}, 1'b0);
    chk("ovr_set", overrun, 1);
    exp1 = model(h_init, blk_a, 32'd64, 32'd0, 1'b0);
    exp2 = model(exp1, blk_b, 32'd128, 32'd0, 1'b0);
    wait_n(50);
    chk("ovr_first_h", h_out, exp1);
    wait_n(110);
    chk("ovr_second_h", h_out, exp2);
    chk("ovr_no_rdy", 256'(rdy_cnt), 0);
    chk("ovr_idle", busy, 0);
    chk("ovr_sticky", overrun, 1);

    rdy_cnt = 0;
    send(abc_m, {32'd3, 32'd0}, 1'b1);
    wait_n(39);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_h", h_out, h_init);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    wait_n(100);
    chk("rst_mid_no_rdy", 256'(rdy_cnt), 0);

    rdy_cnt = 0;
    start = 1'b1;
    msg_strobe = 1'b1;
    tick();
    start = 1'b0;
    msg_strobe = 1'b0;
    m_in = abc_m;
    t_in = {32'd3, 32'd0};
    f_in = 1'b1;
    tick();
    tick();
    chk("start_strobe_busy", busy, 0);
    wait_n(100);
    chk("start_strobe_no_rdy", 256'(rdy_cnt), 0);
    chk("start_strobe_h", h_out, h_init);

    pulse_start();
    rdy_cnt = 0;
    msg_strobe = 1'b1;
    tick();
    m_in = blk_a;
    t_in = {32'd64, 32'd0};
    f_in = 1'b0;
    tick();
    msg_strobe = 1'b0;
    m_in = blk_b;
    t_in = {32'd65, 32'd0};
    f_in = 1'b1;
    tick();
    chk("b2b_pend_busy", busy, 1);
    exp1 = model(model(h_init, blk_a, 32'd64, 32'd0, 1'b0), blk_b, 32'd65, 32'd0, 1'b1);
    wait_n(200);
    chk("b2b_digest", h_out, exp1);
    chk("b2b_one_rdy", 256'(rdy_cnt), 1);
    chk("b2b_idle", busy, 0);
    chk("b2b_no_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
